// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline sequencer for the 3-stage RV32I core (F -> X -> W). It owns the latch enables,
//          the valid bits, redirect squash, the DMEM stall, forwarding selects and the gated reg write.
// Latency: all control outputs are combinational from current state and inputs; valids update on the next clk edge.
// Backpressure: a W-stage load/store without dmem_ack freezes PC, X and W; the access completes with zero extra cycles when acked.
// Optional build macro PIPE_PERF_EN adds the perf_cycles/perf_stalls/perf_flushes counters.
module pipe_hazard_ctrl #(
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter int unsigned PERF_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_F,
    input  logic [31:0] inst_X,
    input  logic [31:0] inst_W,
    input  logic        br_taken_X,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        fx_en,
    output logic        xw_en,
    output logic [31:0] inst_X_next,
    output logic        pc_sel_out,
    output logic        x_valid,
    output logic        w_valid,
    output logic        dmem_req,
    output logic        reg_we_W,
    output logic        fwd_a_sel,
    output logic        fwd_b_sel
`ifdef PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_stalls,
    output logic [PERF_W-1:0] perf_flushes
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic mem_w;
    logic wr_w;
    logic stall;

    // Only the opcode/register fields of the latched instructions matter to this block.
    logic unused_bits;
    assign unused_bits = ^{inst_X[31:25], inst_X[14:0], inst_W[31:12]};

`ifndef PIPE_PERF_EN
    // Counter width only matters when the counters exist.
    logic unused_perf_w;
    assign unused_perf_w = ^PERF_W;
`endif

    // Decode of the W instruction: memory access and register-writing classes.
    always_comb begin
        mem_w = 1'b0;
        wr_w  = 1'b0;
        case (inst_W[6:0])
            7'b0000011: begin mem_w = 1'b1; wr_w = 1'b1; end
            7'b0100011: mem_w = 1'b1;
            7'b0110011,
            7'b0010011,
            7'b0110111,
            7'b0010111,
            7'b1101111,
            7'b1100111: wr_w = 1'b1;
            default: ;
        endcase
        // Writes to x0 are architecturally dropped, so never enable or forward them.
        if (inst_W[11:7] == 5'd0) begin
            wr_w = 1'b0;
        end
    end

    // Next-state and output logic; the stall is recomputed in both states so an ack frees the pipe in the same cycle.
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        dmem_req    = 1'b0;
        pc_en       = 1'b1;
        fx_en       = 1'b1;
        xw_en       = 1'b1;
        pc_sel_out  = 1'b0;
        inst_X_next = inst_F;
        reg_we_W    = 1'b0;
        fwd_a_sel   = 1'b0;
        fwd_b_sel   = 1'b0;

        dmem_req = w_valid & mem_w;
        stall    = w_valid & mem_w & ~dmem_ack;
        pc_en    = ~stall;
        fx_en    = ~stall;
        xw_en    = ~stall;

        // A stall takes precedence: the redirect is replayed once the access completes.
        pc_sel_out = br_taken_X & x_valid & ~stall;
        if (pc_sel_out) begin
            inst_X_next = NOP_INST;
        end

        // A load writes only in its ack cycle, never while it is still waiting.
        reg_we_W  = w_valid & wr_w & ~stall;
        fwd_a_sel = w_valid & wr_w & (inst_W[11:7] == inst_X[19:15]);
        fwd_b_sel = w_valid & wr_w & (inst_W[11:7] == inst_X[24:20]);

        case (state_q)
            RUN:     if (stall) state_d = MEMWAIT;
            MEMWAIT: if (!stall) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage valid bits: hold during a stall, otherwise shift and insert a bubble on redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_valid <= 1'b0;
            w_valid <= 1'b0;
        end else if (!stall) begin
            x_valid <= ~pc_sel_out;
            w_valid <= x_valid;
        end
    end

`ifdef PIPE_PERF_EN
    // Free-running performance counters, wrapping at their natural width.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles  <= '0;
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else begin
            perf_cycles <= perf_cycles + 1'b1;
            if (stall) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
            if (pc_sel_out) begin
                perf_flushes <= perf_flushes + 1'b1;
            end
        end
    end
`endif

endmodule
